bdcpu_program_memory: RTL and testbench

16 x 8 program/data memory that sits on the far side of the bdcpu external memory port (`mem_output_enable`, `mem_write_enable`, `mem_address`, `mem_data`) and answers the CPU's reads and writes. It also owns program loading. A valid/ready byte-stream loader fills memory from address 0, and the block zero-fills every unloaded location. Until loading completes, the block holds the CPU in reset through `cpu_reset_n`.

---
 rtl/bdcpu_program_memory.sv | 133 +++++++++++++
 tb/tb_bdcpu_program_memory.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bdcpu_program_memory.sv
// bdcpu_program_memory
// 16 x 8 program/data memory on the far side of the bdcpu external memory port.
// A valid/ready byte loader fills the array from address 0; the tail that the
// loader did not reach is zero-filled before the CPU is released from reset.
// In RUN the CPU reads combinationally and writes on the clock edge.

module bdcpu_program_memory #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  cpu_reset_n,
  input  logic                  mem_output_enable,
  input  logic                  mem_write_enable,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic [ADDR_WIDTH-1:0]   ptr_d;
  logic [ADDR_WIDTH:0]     count_d;

  // Single shared write port: loader, zero-fill and CPU never overlap in time.
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    cpu_read;

  // Next-state, pointer, counter and write-port selection
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = load_count;
    wr_en   = 1'b0;
    wr_addr = ptr_q;
    wr_data = '0;
    case (state_q)
      S_LOAD: begin
        if (load_valid) begin
          wr_en   = 1'b1;
          wr_data = load_data;
          count_d = load_count + (ADDR_WIDTH + 1)'(1);
          // The last location always ends the load; the pointer parks there
          // instead of wrapping back to 0.
          if (ptr_q == LAST_ADDR) begin
            state_d = S_RUN;
          end else begin
            ptr_d = ptr_q + 1'b1;
            if (load_last) begin
              state_d = S_FILL;
            end
          end
        end
      end
      S_FILL: begin
        wr_en   = 1'b1;
        wr_data = '0;
        if (ptr_q == LAST_ADDR) begin
          state_d = S_RUN;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      S_RUN: begin
        // Both strobes high is a write; the read driver stays off then.
        if (mem_write_enable) begin
          wr_en   = 1'b1;
          wr_addr = mem_address;
          wr_data = mem_data;
        end
        if (load_start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          count_d = '0;
        end
      end
      default: begin
        state_d = S_LOAD;
        ptr_d   = '0;
      end
    endcase
  end

  // Control state: FSM, load pointer, byte counter and CPU reset line
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_LOAD;
      ptr_q       <= '0;
      load_count  <= '0;
      cpu_reset_n <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      load_count  <= count_d;
      cpu_reset_n <= (state_d == S_RUN);
    end
  end

  // Memory array: contents survive reset, writes are suppressed while it is held
  always_ff @(posedge clock) begin
    if (wr_en && !reset) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign load_ready = (state_q == S_LOAD);

  // The bus is only driven for a plain CPU read while the CPU is running.
  assign cpu_read = (state_q == S_RUN) && mem_output_enable && !mem_write_enable;
  assign mem_data = cpu_read ? mem[mem_address] : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_bdcpu_program_memory.sv
// Directed testbench for bdcpu_program_memory: program load with zero-fill,
// full-length load, CPU read/write port behaviour, reload and async reset.

module tb_bdcpu_program_memory;

  logic       clock = 1'b0;
  logic       reset;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic [4:0] load_count;
  logic       cpu_reset_n;
  logic       oe;
  logic       we;
  logic [3:0] addr;
  wire  [7:0] mem_data;
  logic [7:0] drv;
  logic       drv_en;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] prog [13] = '{8'h1E, 8'h2F, 8'h3D, 8'h4C, 8'h5B, 8'h6A, 8'h79,
                            8'h88, 8'h97, 8'hA6, 8'hB5, 8'hC4, 8'hD3};

  // CPU side of the shared data bus
  assign mem_data = drv_en ? drv : 8'hzz;

  bdcpu_program_memory #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clock             (clock),
    .reset             (reset),
    .load_start        (load_start),
    .load_valid        (load_valid),
    .load_data         (load_data),
    .load_last         (load_last),
    .load_ready        (load_ready),
    .load_count        (load_count),
    .cpu_reset_n       (cpu_reset_n),
    .mem_output_enable (oe),
    .mem_write_enable  (we),
    .mem_address       (addr),
    .mem_data          (mem_data)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] d16(input int i);
    return 8'((i * 19 + 129) & 255);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = 8'h00;
    load_last = 1'b0; oe = 1'b0; we = 1'b0; addr = 4'd0; drv = 8'h00; drv_en = 1'b0;

    // Reset state
    tick();
    check("rst_ready", 32'(load_ready), 32'd1);
    check("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    check("rst_count", 32'(load_count), 32'd0);
    reset = 1'b0;

    // 13-byte program, load_last on the 13th byte
    for (int i = 0; i < 13; i++) begin
      load_valid = 1'b1; load_data = prog[i]; load_last = (i == 12);
      tick();
    end
    load_valid = 1'b0; load_last = 1'b0;
    check("p13_count", 32'(load_count), 32'd13);
    check("p13_ready_fill", 32'(load_ready), 32'd0);
    check("p13_cpu_held", 32'(cpu_reset_n), 32'd0);
    tick();
    tick();
    check("p13_fill2_held", 32'(cpu_reset_n), 32'd0);
    tick();
    check("p13_run", 32'(cpu_reset_n), 32'd1);
    check("p13_count_frozen", 32'(load_count), 32'd13);
    oe = 1'b1;
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      #1;
      check($sformatf("p13_mem%0d", i), 32'(mem_data), (i < 13) ? 32'(prog[i]) : 32'd0);
    end
    oe = 1'b0;

    // Reload with 16 bytes and no load_last
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("p16_start_cpu_low", 32'(cpu_reset_n), 32'd0);
    check("p16_start_ready", 32'(load_ready), 32'd1);
    check("p16_start_count", 32'(load_count), 32'd0);
    for (int i = 0; i < 16; i++) begin
      load_valid = 1'b1; load_data = d16(i); load_last = 1'b0;
      tick();
    end
    check("p16_count", 32'(load_count), 32'd16);
    check("p16_run_direct", 32'(cpu_reset_n), 32'd1);
    check("p16_ready_off", 32'(load_ready), 32'd0);
    load_data = 8'hEE;
    tick();
    load_valid = 1'b0;
    check("p16_17th_count", 32'(load_count), 32'd16);
    oe = 1'b1; addr = 4'd0;
    #1;
    check("p16_mem0_kept", 32'(mem_data), 32'(d16(0)));
    addr = 4'd15;
    #1;
    check("p16_mem15", 32'(mem_data), 32'(d16(15)));

    // Combinational read, write then read-back, both strobes
    addr = 4'd4;
    #1;
    check("run_read4", 32'(mem_data), 32'(d16(4)));
    oe = 1'b0; we = 1'b1; addr = 4'd14; drv = 8'h37; drv_en = 1'b1;
    tick();
    we = 1'b0; drv_en = 1'b0; oe = 1'b1;
    #1;
    check("run_raw14", 32'(mem_data), 32'h37);
    oe = 1'b1; we = 1'b1; drv = 8'h48; drv_en = 1'b1;
    #1;
    check("run_oe_we_no_drive", 32'(mem_data), 32'h48);
    tick();
    we = 1'b0; drv_en = 1'b0;
    #1;
    check("run_oe_we_written", 32'(mem_data), 32'h48);
    oe = 1'b0;

    // CPU strobes ignored in LOAD
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    oe = 1'b1; we = 1'b1; addr = 4'd2; drv = 8'hFF; drv_en = 1'b1;
    tick();
    we = 1'b0; drv = 8'h00;
    #1;
    check("load_bus_undriven", 32'(mem_data), 32'h00);
    check("load_mem2_unchanged", 32'(dut.mem[2]), 32'(d16(2)));
    oe = 1'b0; drv_en = 1'b0;

    // Single byte 8'hF0 with load_last -> 15 fill cycles
    load_valid = 1'b1; load_data = 8'hF0; load_last = 1'b1;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    check("one_count", 32'(load_count), 32'd1);
    for (int i = 0; i < 14; i++) tick();
    check("one_fill14_held", 32'(cpu_reset_n), 32'd0);
    tick();
    check("one_run", 32'(cpu_reset_n), 32'd1);
    oe = 1'b1;
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      #1;
      check($sformatf("one_mem%0d", i), 32'(mem_data), (i == 0) ? 32'hF0 : 32'd0);
    end
    oe = 1'b0;

    // Asynchronous reset in the middle of FILL
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = 8'h11; load_last = (i == 2);
      tick();
    end
    load_valid = 1'b0; load_last = 1'b0;
    tick();
    tick();
    check("mid_fill_ready", 32'(load_ready), 32'd0);
    check("mid_fill_count", 32'(load_count), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("async_ready", 32'(load_ready), 32'd1);
    check("async_count", 32'(load_count), 32'd0);
    check("async_cpu_low", 32'(cpu_reset_n), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_ready", 32'(load_ready), 32'd1);
    check("post_reset_cpu_low", 32'(cpu_reset_n), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
